tt_um_leg_solver: RTL

TT_UM_LEG_SOLVER -- requirements
Module: tt_um_leg_solver

---
 rtl/tt_um_leg_solver.sv | 119 +++++++++++
 1 files changed

// File: rtl/tt_um_leg_solver.sv
// Right-triangle leg solver: b = floor(sqrt(h^2 - a^2)) using shift-add squaring
// and a restoring bit-serial square root, sequenced by a five-state FSM.
module tt_um_leg_solver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {IDLE, MUL, SUB, ROOT, DONE} state_t;

  state_t      state, state_nxt;
  logic        first_run;
  logic [7:0]  h_r, a_r;
  logic [15:0] sq_h, sq_a;
  logic [15:0] rad;
  logic [9:0]  rem;
  logic [7:0]  root;
  logic [2:0]  cnt;
  logic        start;
  logic [17:0] step;

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // One restoring root digit: bring down the next radicand bit pair and
  // subtract the trial divisor (4*root + 1) when it fits.
  function automatic logic [17:0] root_step(input logic [9:0] rem_i,
                                            input logic [7:0] root_i,
                                            input logic [1:0] pair);
    logic [11:0] rem_sh;
    logic [11:0] trial;
    logic [11:0] diff;
    rem_sh = {rem_i, pair};
    trial  = {2'b00, root_i, 2'b01};
    diff   = rem_sh - trial;
    if (rem_sh >= trial)
      root_step = {diff[9:0], root_i[6:0], 1'b1};
    else
      root_step = {rem_sh[9:0], root_i[6:0], 1'b0};
  endfunction

  assign start = (state == IDLE) && (first_run || (ui_in != h_r) || (uio_in != a_r));
  assign step  = root_step(rem, root, rad[15:14]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else if (ena)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (cnt == 3'd7) state_nxt = SUB;
      SUB:     state_nxt = ROOT;
      ROOT:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_run <= 1'b1;
      h_r       <= 8'd0;
      a_r       <= 8'd0;
      sq_h      <= 16'd0;
      sq_a      <= 16'd0;
      rad       <= 16'd0;
      rem       <= 10'd0;
      root      <= 8'd0;
      cnt       <= 3'd0;
      uo_out    <= 8'd0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            h_r       <= ui_in;
            a_r       <= uio_in;
            first_run <= 1'b0;
            sq_h      <= 16'd0;
            sq_a      <= 16'd0;
            cnt       <= 3'd0;
          end
        end
        MUL: begin
          // Multiplier bit cnt of each operand selects a shifted copy of itself.
          if (h_r[cnt]) sq_h <= sq_h + ({8'd0, h_r} << cnt);
          if (a_r[cnt]) sq_a <= sq_a + ({8'd0, a_r} << cnt);
          cnt <= cnt + 3'd1;
        end
        SUB: begin
          rad  <= (sq_a > sq_h) ? 16'd0 : (sq_h - sq_a);
          rem  <= 10'd0;
          root <= 8'd0;
          cnt  <= 3'd0;
        end
        ROOT: begin
          rem  <= step[17:8];
          root <= step[7:0];
          rad  <= {rad[13:0], 2'b00};
          cnt  <= cnt + 3'd1;
        end
        DONE: begin
          uo_out <= root;
        end
        default: ;
      endcase
    end
  end

endmodule
